// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch bus: request/grant handshake plus in-order response.
// The fetch unit is the master; the instruction memory is the slave.
interface if_fetch_unit_if #(
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage controller: one outstanding fetch, a 1-entry hold buffer
// for decode back-pressure, and discard of stale responses after a PC redirect.
module if_fetch_unit #(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  pc,
  input  logic               redirect,
  input  logic               id_stall,
  if_fetch_unit_if.master    imem,
  output logic               if_stall,
  output logic               ifid_valid,
  output logic [DATA_W-1:0]  ifid_pc,
  output logic [DATA_W-1:0]  ifid_instr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [DATA_W-1:0] req_pc;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_pc;
  logic [DATA_W-1:0] hold_instr;
  logic              grant;
  logic              resp;

  // A new request may go out from IDLE, or from WAIT in the same cycle the
  // previous response lands, which keeps zero-wait memory at full rate.
  assign imem.imem_req  = ~rst & ~redirect & ~id_stall & ~hold_valid &
                          ((state_q == IDLE) | ((state_q == WAIT) & imem.imem_rvalid));
  assign imem.imem_addr = pc;
  assign grant          = imem.imem_req & imem.imem_gnt;
  assign resp           = (state_q == WAIT) & imem.imem_rvalid;
  assign if_stall       = rst | (~redirect & ~grant);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = grant ? WAIT : IDLE;
      WAIT: begin
        if (redirect)                state_d = imem.imem_rvalid ? IDLE : DROP;
        else if (imem.imem_rvalid)   state_d = grant ? WAIT : IDLE;
        else                         state_d = WAIT;
      end
      DROP: state_d = imem.imem_rvalid ? IDLE : DROP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_pc  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) req_pc <= pc;
    end
  end

  // IF/ID register and hold buffer control; flush outranks decode back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      hold_valid <= 1'b0;
    end else if (redirect) begin
      ifid_valid <= 1'b0;
      hold_valid <= 1'b0;
    end else if (!id_stall) begin
      if (hold_valid) begin
        ifid_valid <= 1'b1;
        ifid_pc    <= hold_pc;
        ifid_instr <= hold_instr;
        hold_valid <= 1'b0;
      end else if (resp) begin
        ifid_valid <= 1'b1;
        ifid_pc    <= req_pc;
        ifid_instr <= imem.imem_rdata;
      end else begin
        ifid_valid <= 1'b0;
      end
    end else if (resp) begin
      hold_valid <= 1'b1;
    end
  end

  // Hold payload is qualified by hold_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!redirect && id_stall && resp) begin
      hold_pc    <= req_pc;
      hold_instr <= imem.imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: cycle-by-cycle memory/pipeline stimulus with
// hand-computed expectations for outputs, FSM state and hold buffer.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] XK  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        redirect;
  logic        id_stall;
  logic        if_stall;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;

  int n_chk  = 0;
  int n_fail = 0;
  int idle_rv_seen = 0;
  logic expect_idle_rv = 1'b0;

  if_fetch_unit_if bus ();

  if_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .redirect   (redirect),
    .id_stall   (id_stall),
    .imem       (bus.master),
    .if_stall   (if_stall),
    .ifid_valid (ifid_valid),
    .ifid_pc    (ifid_pc),
    .ifid_instr (ifid_instr)
  );

  always #5 clk = ~clk;

  // A response while IDLE is a protocol violation unless a test provokes it on purpose.
  always @(negedge clk) begin
    if (!rst && dut.state_q == 2'd0 && bus.imem_rvalid) begin
      idle_rv_seen++;
      assert (expect_idle_rv) else $error("protocol: imem_rvalid while IDLE");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] p, input logic rd, input logic ids,
                       input logic g, input logic rv, input logic [31:0] rdat);
    pc              = p;
    redirect        = rd;
    id_stall        = ids;
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rdat;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    tick();
    // Reset values; redirect must not release the stall during reset.
    drive(32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("rst_req", bus.imem_req, 0);
    chk("rst_stall", if_stall, 1);
    chk("rst_valid", ifid_valid, 0);
    chk("rst_pc", ifid_pc, 0);
    chk("rst_instr", ifid_instr, NOP);
    tick();

    // Zero-wait memory, back-to-back fetches.
    rst = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("zw_req0", bus.imem_req, 1);
    chk("zw_addr0", bus.imem_addr, 32'h0);
    chk("zw_stall0", if_stall, 0);
    tick();
    chk("zw_bubble", ifid_valid, 0);
    drive(32'h4, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0 ^ XK);
    chk("zw_req1", bus.imem_req, 1);
    chk("zw_stall1", if_stall, 0);
    tick();
    chk("zw_v0", ifid_valid, 1);
    chk("zw_pc0", ifid_pc, 32'h0);
    chk("zw_i0", ifid_instr, 32'hA5A5_0000);
    drive(32'h8, 1'b0, 1'b0, 1'b1, 1'b1, 32'h4 ^ XK);
    tick();
    chk("zw_v1", ifid_valid, 1);
    chk("zw_pc1", ifid_pc, 32'h4);
    chk("zw_i1", ifid_instr, 32'hA5A5_0004);
    drive(32'hC, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8 ^ XK);
    tick();
    chk("zw_pc2", ifid_pc, 32'h8);
    chk("zw_i2", ifid_instr, 32'hA5A5_0008);
    drive(32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC ^ XK);
    chk("zw_nogrant_stall", if_stall, 1);
    tick();
    chk("zw_pc3", ifid_pc, 32'hC);
    chk("zw_idle", dut.state_q, 2'd0);

    // Late grant, k=3 response.
    drive(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("lg_req_wait_gnt", bus.imem_req, 1);
    chk("lg_stall_wait_gnt", if_stall, 1);
    tick();
    chk("lg_bubble", ifid_valid, 0);
    chk("lg_pc_kept", ifid_pc, 32'hC);
    drive(32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("lg_stall_gnt", if_stall, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(32'h44, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("lg_one_outstanding", bus.imem_req, 0);
      chk("lg_stall_outstanding", if_stall, 1);
      tick();
    end
    drive(32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_0040);
    tick();
    chk("lg_v", ifid_valid, 1);
    chk("lg_pc", ifid_pc, 32'h40);
    chk("lg_i", ifid_instr, 32'h1111_0040);
    drive(32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("lg_bubble2", ifid_valid, 0);
    chk("lg_pc2_kept", ifid_pc, 32'h40);
    drive(32'h44, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    // Response for 0x44 with back-to-back grant of 0x10.
    drive(32'h10, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_0044);
    tick();
    chk("lg_pc44", ifid_pc, 32'h44);
    chk("lg_v44", ifid_valid, 1);

    // Decode stall while the 0x10 response arrives.
    drive(32'h14, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD_0010);
    chk("st_req_blocked", bus.imem_req, 0);
    chk("st_stall", if_stall, 1);
    tick();
    chk("st_hold_v", dut.hold_valid, 1);
    chk("st_hold_pc", dut.hold_pc, 32'h10);
    chk("st_ifid_v", ifid_valid, 1);
    chk("st_ifid_pc", ifid_pc, 32'h44);
    for (int i = 0; i < 2; i++) begin
      drive(32'h14, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("st_req_held", bus.imem_req, 0);
      tick();
      chk("st_ifid_hold", ifid_pc, 32'h44);
    end
    drive(32'h14, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("st_req_while_hold", bus.imem_req, 0);
    tick();
    chk("st_rel_v", ifid_valid, 1);
    chk("st_rel_pc", ifid_pc, 32'h10);
    chk("st_rel_i", ifid_instr, 32'hDEAD_0010);
    chk("st_hold_clr", dut.hold_valid, 0);
    drive(32'h14, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("st_next_req", bus.imem_req, 1);
    chk("st_next_addr", bus.imem_addr, 32'h14);
    tick();
    drive(32'h20, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_0014);
    tick();
    chk("rd_pc14", ifid_pc, 32'h14);

    // Redirect in WAIT for 0x20, response two cycles later, target 0x100.
    drive(32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("rd_req", bus.imem_req, 0);
    chk("rd_stall", if_stall, 0);
    tick();
    chk("rd_drop", dut.state_q, 2'd2);
    chk("rd_flush", ifid_valid, 0);
    drive(32'h100, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("rd_drop_noreq", bus.imem_req, 0);
    chk("rd_drop_stall", if_stall, 1);
    tick();
    drive(32'h100, 1'b0, 1'b0, 1'b1, 1'b1, 32'hBAD0_0020);
    chk("rd_drop_noreq2", bus.imem_req, 0);
    tick();
    chk("rd_discard_v", ifid_valid, 0);
    chk("rd_discard_pc", ifid_pc, 32'h14);
    chk("rd_idle", dut.state_q, 2'd0);
    drive(32'h100, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("rd_tgt_req", bus.imem_req, 1);
    chk("rd_tgt_addr", bus.imem_addr, 32'h100);
    tick();
    drive(32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0010_0113);
    tick();
    chk("rd_tgt_pc", ifid_pc, 32'h100);
    chk("rd_tgt_i", ifid_instr, 32'h0010_0113);

    // Redirect together with id_stall while the hold buffer is full.
    drive(32'h104, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    drive(32'h108, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0055);
    tick();
    chk("rf_hold_v", dut.hold_valid, 1);
    drive(32'h108, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rf_stall", if_stall, 0);
    tick();
    chk("rf_ifid_v", ifid_valid, 0);
    chk("rf_hold_clr", dut.hold_valid, 0);
    drive(32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("rf_req", bus.imem_req, 1);
    tick();
    chk("rf_wait", dut.state_q, 2'd1);

    // Reset pulse while in WAIT, then a stale response after release.
    rst = 1'b1;
    drive(32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rw_valid", ifid_valid, 0);
    chk("rw_pc", ifid_pc, 0);
    chk("rw_instr", ifid_instr, NOP);
    chk("rw_req", bus.imem_req, 0);
    chk("rw_stall", if_stall, 1);
    chk("rw_state", dut.state_q, 2'd0);
    tick();
    rst = 1'b0;
    expect_idle_rv = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBAD0_0200);
    tick();
    expect_idle_rv = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rw_late_v", ifid_valid, 0);
    chk("rw_late_instr", ifid_instr, NOP);
    chk("rw_late_state", dut.state_q, 2'd0);
    chk("idle_rvalid_count", idle_rv_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
